// File: rtl/i2s_tx_stream_pkg.sv
// Shared constants and types for the I2S stream transmitter.
package i2s_tx_pkg;

    localparam int W_DEF           = 32;
    localparam int LSB_DEF         = 8;
    localparam int SAMPLE_BITS_DEF = 16;
    localparam int BCLK_DIV_DEF    = 4;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } slot_index_e;

    // A frame holds two slots, so the bit counter must span 2*sample_bits values.
    function automatic int bit_cnt_width(input int sample_bits);
        return $clog2(2 * sample_bits);
    endfunction

endpackage

// File: rtl/i2s_tx_stream_if.sv
// Valid/ready sample stream carrying two's complement fixed-point words.
interface i2s_tx_stream_if #(
    parameter int W = i2s_tx_pkg::W_DEF
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/i2s_tx_stream_clkgen.sv
// Bit-clock and word-select timing for the I2S transmitter.
// bit_index_o is the bit period about to begin; it is meaningful while shift_en_o is high.
module i2s_tx_clkgen
    import i2s_tx_pkg::*;
#(
    parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
    parameter int BCLK_DIV    = BCLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic bclk_o,
    output logic lrclk_o,
    output logic frame_start_o,
    output logic shift_en_o,
    output logic [bit_cnt_width(SAMPLE_BITS)-1:0] bit_index_o
);

    localparam int BW = bit_cnt_width(SAMPLE_BITS);
    localparam int DW = $clog2(BCLK_DIV);

    localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] B_LAST    = BW'(2 * SAMPLE_BITS - 1);
    localparam logic [BW-1:0] B_LR_RISE = BW'(SAMPLE_BITS - 1);
    localparam logic [BW-1:0] B_LR_FALL = BW'(2 * SAMPLE_BITS - 2);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          bclk_q, lrclk_q;
    logic          shift_en;
    slot_index_e   slot_d;

    // Next counter values; the right slot's word select leads its MSB by one bit.
    always_comb begin
        shift_en  = (div_cnt_q == DIV_LAST);
        div_cnt_d = shift_en ? '0 : div_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        if (shift_en) begin
            bit_cnt_d = (bit_cnt_q == B_LAST) ? '0 : bit_cnt_q + 1'b1;
        end
        slot_d = ((bit_cnt_d >= B_LR_RISE) && (bit_cnt_d <= B_LR_FALL)) ? RIGHT : LEFT;
    end

    // Counters and registered bclk/lrclk; lrclk only moves on the bclk falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            bclk_q    <= (div_cnt_d >= DIV_HALF);
            if (shift_en) begin
                lrclk_q <= (slot_d == RIGHT);
            end
        end
    end

    assign bclk_o        = bclk_q;
    assign lrclk_o       = lrclk_q;
    assign shift_en_o    = shift_en;
    assign frame_start_o = shift_en && (bit_cnt_q == B_LAST);
    assign bit_index_o   = bit_cnt_d;

endmodule

// File: rtl/i2s_tx_stream.sv
// Streaming mono I2S transmitter: each accepted sample is sent in both slots.
// Optional build macro I2S_TX_STREAM_SAT_EN: saturate out-of-range samples
// instead of truncating them.
module i2s_tx_stream
    import i2s_tx_pkg::*;
#(
    parameter int W           = W_DEF,
    parameter int LSB         = LSB_DEF,
    parameter int SAMPLE_BITS = SAMPLE_BITS_DEF,
    parameter int BCLK_DIV    = BCLK_DIV_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    i2s_tx_stream_if.slave  x,
    output logic            i2s_bclk,
    output logic            i2s_lrclk,
    output logic            i2s_sdata,
    output logic            underrun
);

    localparam int BW = bit_cnt_width(SAMPLE_BITS);
    localparam int SW = $clog2(SAMPLE_BITS);

    logic [SAMPLE_BITS-1:0] pending_q, pending_d;
    logic [SAMPLE_BITS-1:0] frame_q, frame_d;
    logic                   pending_full_q, pending_full_d;
    logic                   primed_q, primed_d;
    logic                   underrun_q, underrun_d;
    logic                   sdata_q, sdata_d;

    logic                   frame_start, shift_en, hs;
    logic [BW-1:0]          bit_index;
    logic [SW-1:0]          bit_sel;
    logic [SAMPLE_BITS-1:0] sample_red;

    i2s_tx_clkgen #(
        .SAMPLE_BITS (SAMPLE_BITS),
        .BCLK_DIV    (BCLK_DIV)
    ) u_clkgen (
        .clk           (clk),
        .rst_n         (rst_n),
        .bclk_o        (i2s_bclk),
        .lrclk_o       (i2s_lrclk),
        .frame_start_o (frame_start),
        .shift_en_o    (shift_en),
        .bit_index_o   (bit_index)
    );

    assign x.ready = !pending_full_q;
    assign hs      = x.valid && !pending_full_q;

    // Reduce the input word to slot width, clamping when the dropped high bits carry magnitude.
    always_comb begin
        sample_red = x.data[LSB+SAMPLE_BITS-1:LSB];
`ifdef I2S_TX_STREAM_SAT_EN
        if (!((&x.data[W-1:LSB+SAMPLE_BITS-1]) || !(|x.data[W-1:LSB+SAMPLE_BITS-1]))) begin
            sample_red = x.data[W-1] ? {1'b1, {(SAMPLE_BITS-1){1'b0}}}
                                     : {1'b0, {(SAMPLE_BITS-1){1'b1}}};
        end
`endif
    end

    // Both slots send the same word MSB first; map bit period to frame bit.
    always_comb begin
        if (bit_index < BW'(SAMPLE_BITS)) begin
            bit_sel = SW'(SAMPLE_BITS - 1) - bit_index[SW-1:0];
        end else begin
            bit_sel = SW'(2 * SAMPLE_BITS - 1) - bit_index[SW-1:0];
        end
    end

    // Pending/frame hand-off at frame start; a same-cycle handshake never bypasses pending.
    always_comb begin
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        frame_d        = frame_q;
        primed_d       = primed_q || hs;
        underrun_d     = 1'b0;
        sdata_d        = sdata_q;
        if (frame_start) begin
            if (pending_full_q) begin
                frame_d        = pending_q;
                pending_full_d = 1'b0;
            end else begin
                frame_d    = '0;
                underrun_d = primed_q;
            end
        end
        if (hs) begin
            pending_d      = sample_red;
            pending_full_d = 1'b1;
        end
        if (shift_en) begin
            sdata_d = frame_d[bit_sel];
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            frame_q        <= '0;
            primed_q       <= 1'b0;
            underrun_q     <= 1'b0;
            sdata_q        <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            frame_q        <= frame_d;
            primed_q       <= primed_d;
            underrun_q     <= underrun_d;
            sdata_q        <= sdata_d;
        end
    end

    assign i2s_sdata = sdata_q;
    assign underrun  = underrun_q;

endmodule
